// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave terminating a bank of NUM_REGS registers with byte strobes,
// read-only status registers, SLVERR decode and per-register access strobes.
module axi_lite_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]            RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            reg_wr_stb,
  output logic [NUM_REGS-1:0]            reg_rd_stb
);

  localparam int          STRB_W = DATA_WIDTH / 8;
  localparam int          LSB    = $clog2(STRB_W);
  localparam int          IDX_W  = ADDR_WIDTH - LSB;
  localparam int unsigned NREG   = NUM_REGS;
  localparam int unsigned NSTRB  = STRB_W;

  logic                  rdy_q, rdy_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
  logic [NUM_REGS-1:0]   rd_stb_q, rd_stb_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [IDX_W-1:0]      ar_idx;
  logic                  unused_bits;

  // rdy_q keeps all ready outputs low until the first edge after reset release
  assign s_axi_awready = rdy_q & ~aw_held_q & ~bvalid_q;
  assign s_axi_wready  = rdy_q & ~w_held_q & ~bvalid_q;
  assign s_axi_arready = rdy_q & ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign reg_wr_stb    = wr_stb_q;
  assign reg_rd_stb    = rd_stb_q;
  assign ar_idx        = s_axi_araddr[ADDR_WIDTH-1:LSB];
  assign unused_bits   = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0], reg_in};

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NREG; i++)
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  always_comb begin
    rdy_d     = 1'b1;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    wr_stb_d  = '0;
    rd_stb_d  = '0;
    regs_d    = regs_q;

    if (s_axi_awvalid && s_axi_awready) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi_awaddr[ADDR_WIDTH-1:LSB];
    end
    if (s_axi_wvalid && s_axi_wready) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    // Held AW/W stay set until the B handshake, which blocks re-acceptance
    if (bvalid_q) begin
      if (s_axi_bready) begin
        bvalid_d  = 1'b0;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
    end else if (aw_held_q && w_held_q) begin
      bvalid_d = 1'b1;
      bresp_d  = 2'b10;
      for (int unsigned i = 0; i < NREG; i++) begin
        if (aw_idx_q == IDX_W'(i) && !RO_MASK[i]) begin
          bresp_d     = 2'b00;
          wr_stb_d[i] = 1'b1;
          for (int unsigned b = 0; b < NSTRB; b++)
            if (wstrb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end

    if (s_axi_arvalid && s_axi_arready) begin
      rvalid_d = 1'b1;
      rresp_d  = 2'b10;
      rdata_d  = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        if (ar_idx == IDX_W'(i)) begin
          rresp_d     = 2'b00;
          rd_stb_d[i] = 1'b1;
          rdata_d     = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        end
      end
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      wr_stb_q  <= '0;
      rd_stb_q  <= '0;
      for (int unsigned i = 0; i < NREG; i++)
        regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      rdy_q     <= rdy_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      regs_q    <= regs_d;
    end
  end

endmodule
